// File: rtl/fpgabpf_rx_pkg.sv
// Shared types and constants for the AXI-Stream packet receiver.
package fpgabpf_rx_pkg;

    localparam int unsigned BEAT_BYTES = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } rx_state_e;

endpackage

// File: rtl/axistream_receiver_if.sv
// 64-bit AXI-Stream link into the receiver; TKEEP exists only with RX_TKEEP_EN.
interface axistream_receiver_if;

    logic [63:0] TDATA;
    logic        TVALID;
    logic        TREADY;
    logic        TLAST;
`ifdef RX_TKEEP_EN
    logic [7:0]  TKEEP;
`endif

`ifdef RX_TKEEP_EN
    modport master (output TDATA, output TVALID, output TLAST, output TKEEP, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, input TKEEP, output TREADY);
`else
    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
`endif

endinterface

// File: rtl/rx_keep_bytecount.sv
// Combinational popcount of an 8-bit byte-enable mask.
module rx_keep_bytecount (
    input  logic [7:0] keep,
    output logic [3:0] byte_count_c
);

    always_comb begin
        byte_count_c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            byte_count_c = byte_count_c + 4'(keep[i]);
        end
    end

endmodule

// File: rtl/axistream_receiver.sv
// AXI-Stream slave that splits 64-bit beats into 32-bit packet-memory writes.
// Optional feature macro: RX_TKEEP_EN (partial last beat via TKEEP).
module axistream_receiver
    import fpgabpf_rx_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    axistream_receiver_if.slave   s_axis,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  wr_en,
    input  logic                  mem_ready,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  len,
    output logic                  overflow
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_CAP = LEN_WIDTH'(WORD_BYTES) << ADDR_WIDTH;

    rx_state_e             state;
    logic                  tready_q;
    logic [CNT_W-1:0]      word_idx;
    logic [31:0]           hi_word;
    logic                  last_q;

    logic                  hs_c;
    logic                  full_c;
    logic                  skip_hi_c;
    logic [3:0]            beat_bytes_c;
    logic [LEN_WIDTH-1:0]  len_sum_c;
    logic [LEN_WIDTH-1:0]  len_next_c;

    assign s_axis.TREADY = tready_q;
    assign hs_c          = s_axis.TVALID & tready_q;
    // Top bit of the word index marks the memory as full; the index never wraps.
    assign full_c        = word_idx[ADDR_WIDTH];

`ifdef RX_TKEEP_EN
    logic [3:0] keep_count_c;

    rx_keep_bytecount u_keep (
        .keep         (s_axis.TKEEP),
        .byte_count_c (keep_count_c)
    );

    assign beat_bytes_c = s_axis.TLAST ? keep_count_c : 4'(BEAT_BYTES);
    assign skip_hi_c    = s_axis.TLAST && (s_axis.TKEEP[7:4] == 4'd0);
`else
    assign beat_bytes_c = 4'(BEAT_BYTES);
    assign skip_hi_c    = 1'b0;
`endif

    // Length saturates at the memory's byte capacity.
    always_comb begin
        len_sum_c  = len + LEN_WIDTH'(beat_bytes_c);
        len_next_c = (len_sum_c > LEN_CAP) ? LEN_CAP : len_sum_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tready_q <= 1'b0;
            word_idx <= '0;
            hi_word  <= 32'd0;
            last_q   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 32'd0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            len      <= '0;
            overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_ready) begin
                        state    <= LO;
                        tready_q <= 1'b1;
                        word_idx <= '0;
                        len      <= '0;
                        overflow <= 1'b0;
                    end
                end
                LO: begin
                    if (hs_c) begin
                        tready_q <= 1'b0;
                        hi_word  <= s_axis.TDATA[63:32];
                        last_q   <= s_axis.TLAST;
                        len      <= len_next_c;
                        if (!full_c) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= word_idx[ADDR_WIDTH-1:0];
                            wr_data  <= s_axis.TDATA[31:0];
                            word_idx <= word_idx + CNT_W'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                        state <= skip_hi_c ? DONE : HI;
                    end
                end
                HI: begin
                    if (!full_c) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= word_idx[ADDR_WIDTH-1:0];
                        wr_data  <= hi_word;
                        word_idx <= word_idx + CNT_W'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                    if (last_q) begin
                        state <= DONE;
                    end else begin
                        state    <= LO;
                        tready_q <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
